// File: rtl/mod_counter_bank.sv
// mod_counter_bank: a bank of CHANNELS up/down counters, each WIDTH bits wide.
// Each channel can count on its own (CASCADE=0). With CASCADE=1 the channels
// chain LSB-first into one CHANNELS*WIDTH counter. Every channel updates on
// the same CLK edge; there is no ripple clocking between channels.
// Optional feature: define COUNTER_BANK_LOAD_EN to add the LOAD/D parallel-load
// ports. Without that macro the load path is tied off and the ports do not exist.
module mod_counter_bank #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int CASCADE  = 0
) (
    input  logic                      CLK,
    input  logic                      CLR_N,
    input  logic [CHANNELS-1:0]       EN,
    input  logic [CHANNELS-1:0]       SCLR,
    input  logic [CHANNELS-1:0]       UP,
`ifdef COUNTER_BANK_LOAD_EN
    input  logic [CHANNELS-1:0]       LOAD,
    input  logic [CHANNELS*WIDTH-1:0] D,
`endif
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       TC,
    output logic                      CO
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    // Counter state, one WIDTH-bit slice per channel, packed the same way as Q.
    logic [CHANNELS-1:0][WIDTH-1:0] r_q;
    logic [CHANNELS-1:0][WIDTH-1:0] w_next;
    logic [CHANNELS-1:0][WIDTH-1:0] w_d;
    logic [CHANNELS-1:0]            w_load;
    logic [CHANNELS-1:0]            w_tc;
    logic [CHANNELS-1:0]            w_adv;
    logic [CHANNELS-1:0]            w_ripple;

`ifdef COUNTER_BANK_LOAD_EN
    assign w_load = LOAD;
    assign w_d    = D;
`else
    assign w_load = '0;
    assign w_d    = '0;
`endif

    // Terminal count: the value that wraps on the next step in this channel's direction.
    always_comb begin
        w_tc = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_tc[i] = UP[i] ? (r_q[i] == ALL_ONES) : (r_q[i] == '0);
        end
    end

    // Advance and carry chain; a clear or load on a channel blocks its carry upward.
    always_comb begin
        logic w_carry;
        w_adv    = '0;
        w_ripple = '0;
        w_carry  = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CASCADE != 0) begin
                w_adv[i] = EN[i] & w_carry;
            end else begin
                w_adv[i] = EN[i];
            end
            w_ripple[i] = w_adv[i] & w_tc[i] & ~SCLR[i] & ~w_load[i];
            w_carry     = w_ripple[i];
        end
    end

    // Per-channel next value: clear beats load, load beats counting, otherwise hold.
    always_comb begin
        w_next = r_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SCLR[i]) begin
                w_next[i] = '0;
            end else if (w_load[i]) begin
                w_next[i] = w_d[i];
            end else if (w_adv[i]) begin
                w_next[i] = UP[i] ? (r_q[i] + ONE) : (r_q[i] - ONE);
            end
        end
    end

    // State register; CLR_N clears every channel at once without waiting for a clock.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign Q  = r_q;
    assign TC = w_tc;
    assign CO = w_ripple[CHANNELS-1];

endmodule
